// File: rtl/seq_mul6.sv
// seq_mul6: 6-bit unsigned shift-add multiplier built around an external prefix adder.
// Optional feature: define SEQ_MUL6_ZERO_BYPASS_EN to short-cut zero operands straight to DONE.
module seq_mul6 #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic [WIDTH-1:0]   add_x,
  output logic [WIDTH-1:0]   add_y,
  input  logic [WIDTH-1:0]   add_s,
  input  logic               add_cout,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [2:0]       cnt_q, cnt_d;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_hi_q <= {WIDTH{1'b0}};
      acc_lo_q <= {WIDTH{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      cnt_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic: load in IDLE, one adder pass plus right shift per RUN cycle.
  always_comb begin
    state_d  = state_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_hi_d = {WIDTH{1'b0}};
          acc_lo_d = b;
          mcand_d  = a;
          cnt_d    = CNT_INIT;
          state_d  = ST_RUN;
`ifdef SEQ_MUL6_ZERO_BYPASS_EN
          if ((a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}})) begin
            acc_lo_d = {WIDTH{1'b0}};
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_RUN;
          end
`else
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // The adder carry becomes the new top bit of the shifted accumulator.
        {acc_hi_d, acc_lo_d} = {add_cout, add_s, acc_lo_q[WIDTH-1:1]};
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // in_ready is gated by rst_n so nothing is accepted while reset is asserted.
  assign in_ready  = (state_q == ST_IDLE) && rst_n;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign p         = {acc_hi_q, acc_lo_q};
  assign add_x     = acc_hi_q;
  assign add_y     = acc_lo_q[0] ? mcand_q : {WIDTH{1'b0}};

endmodule
